line_fill_mem: RTL and testbench
================================

Name: line_fill_mem

Overview:
- Backing-memory responder on the miss side of the direct-mapped cache.
- The cache issues a line-fill request with a byte address. This block returns the full line as a burst of words, critical word first, after a fixed access latency.
- Provides the memory end of the cache refill interface; the cache is the initiator.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- WORDS_PER_LINE, 4, words per cache line (power of two, >=2)
- MEM_DEPTH_WORDS, 1024, storage depth in words (power of two)
- READ_LATENCY, 3, edges from request acceptance to first beat (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  fill request valid
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_WIDTH  byte address of requested word
- resp_valid  out  1  response beat valid
- resp_ready  in  1  cache accepts beat
- resp_data  out  DATA_WIDTH  line word
- resp_word  out  log2(WORDS_PER_LINE)  word offset of resp_data within line
- resp_last  out  1  final beat of line
- busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: req_ready=0 while rst_n low, then 1 (IDLE); resp_valid=0, resp_data=0, resp_word=0, resp_last=0, busy=0.
- Storage: memory array is not reset. Time-zero contents are mem[i]=i (zero-extended).
- Address mapping:
  - word index = (req_addr>>2) mod MEM_DEPTH_WORDS (upper bits ignored; wraps around).
  - offset = word index mod WORDS_PER_LINE.
  - line base = word index with offset bits cleared.
  - req_addr[1:0] ignored.
- State machine: IDLE, WAIT, BURST.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at an edge: capture line base and offset, load latency counter, go to WAIT.
- WAIT:
  - req_ready=0; counter decrements each edge.
  - First beat is registered so that resp_valid is visible after exactly READ_LATENCY edges counted from the acceptance edge.
  - With READ_LATENCY=1, the beat appears the cycle after acceptance.
- BURST:
  - Beat k (k=0..WORDS_PER_LINE-1) carries mem[base + ((offset+k) mod WORDS_PER_LINE)] with resp_word=(offset+k) mod WORDS_PER_LINE.
  - Order is critical word first, wrapping within the line.
  - A beat advances only on resp_valid&&resp_ready.
  - While resp_ready=0, resp_data, resp_word and resp_last are held stable and resp_valid stays 1.
  - resp_last=1 only on beat WORDS_PER_LINE-1.
  - Back-to-back beats are allowed: one per cycle when resp_ready is held high.
  - After the last handshake: go to IDLE; resp_valid drops next cycle; req_ready rises the same cycle.
  - A new request is never accepted in the cycle of the last handshake.
- Request while busy: req_valid is ignored (not queued) until req_ready=1; the cache holds req_valid/req_addr stable.
- Reset mid-operation: rst_n low in any state aborts immediately; outputs go to reset values; state goes to IDLE; memory contents are preserved.

Optional Feature:
- Macro: LINE_FILL_MEM_WRITE_EN.
- Enabled:
  - Adds ports req_we (in 1), wr_valid (in 1), wr_ready (out 1), wr_data (in DATA_WIDTH).
  - Request accepted with req_we=1 goes to state WRITE.
  - In WRITE, wr_ready=1 and WORDS_PER_LINE beats are accepted on wr_valid&&wr_ready, written to base+0, base+1, … in ascending order; the request offset is ignored.
  - After the last write beat: return to IDLE; no resp beats are produced.
  - A read issued after the write returns the new data.
- Disabled: these ports and the WRITE state do not exist; every request is a read fill.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> all outputs 0, busy=0; after release req_ready=1.
- Fill 0x0000_005F, resp_ready=1:
  - First resp_valid exactly 3 edges after acceptance.
  - Beats data 23,20,21,22 with resp_word 3,0,1,2; resp_last only on 22.
  - req_ready=1 the cycle after last.
- Fill 0x0000_0040 with resp_ready toggled 1,0,0,1,1,0,1 -> data 16,17,18,19 in order; data/word/last held constant during stalls; no beat lost or repeated.
- Address wrap: fill 0x0000_1018 -> word index 1030 mod 1024 = 6; beats 6,7,4,5; resp_last on 5.
- Reset mid-burst: assert rst_n=0 after beat 1 of fill 0x5F -> resp_valid=0 immediately (async). After release, fill 0x5F again -> full sequence 23,20,21,22.
- With LINE_FILL_MEM_WRITE_EN: write line at 0x40 with 0xDEADBEEF, 0x1, 0x2, 0x3, then fill 0x48 -> beats 0x2, 0x3, 0xDEADBEEF, 0x1, resp_word 2,3,0,1.

Source files
------------

// File: rtl/line_fill_mem.sv
// rtl/line_fill_mem.sv - backing-memory line-fill responder for the cache miss path
//
// Returns a full cache line as a burst of words, critical word first, a fixed
// number of edges after a fill request is accepted.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready        fill request handshake
//   req_addr                   byte address of the requested word
//   resp_valid/resp_ready      response beat handshake
//   resp_data                  line word carried by the current beat
//   resp_word                  word offset of resp_data within the line
//   resp_last                  final beat of the line
//   busy                       high whenever the block is not idle
//
// Optional feature (macro LINE_FILL_MEM_WRITE_EN):
//   req_we                     request is a line write instead of a fill
//   wr_valid/wr_ready          write beat handshake
//   wr_data                    write beat data, stored base+0, base+1, ...

module line_fill_mem #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_LINE  = 4,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int READ_LATENCY    = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [DATA_WIDTH-1:0]             resp_data,
    output logic [$clog2(WORDS_PER_LINE)-1:0] resp_word,
    output logic                              resp_last,
`ifdef LINE_FILL_MEM_WRITE_EN
    input  logic                              req_we,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [DATA_WIDTH-1:0]             wr_data,
`endif
    output logic                              busy
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(MEM_DEPTH_WORDS);
    localparam int LINE_W = IDX_W - OFF_W;
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
`ifdef LINE_FILL_MEM_WRITE_EN
        ,
        S_WRITE = 2'd3
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [OFF_W-1:0]      beat_q, beat_d;
    logic [OFF_W-1:0]      word_q, word_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;

    logic [IDX_W-1:0]      req_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [OFF_W-1:0]      nxt_word;
    logic [OFF_W-1:0]      nxt_beat;
    logic                  accept;
    logic                  beat_hs;
    logic                  lat_done;
    logic                  unused_addr;

    // Byte-lane bits and bits above the storage depth do not select a word.
    assign req_idx     = req_addr[IDX_W+1:2];
    assign unused_addr = ^req_addr;

    assign accept   = req_valid && req_ready;
    assign beat_hs  = resp_valid && resp_ready;
    assign lat_done = (lat_q == '0);
    assign nxt_word = word_q + OFF_W'(1);
    assign nxt_beat = beat_q + OFF_W'(1);

    // The first beat reads the critical word; later beats read the next word
    // of the line, wrapping inside the line through the narrow offset adder.
    assign rd_idx = {line_q, (state_q == S_BURST) ? nxt_word : off_q};

`ifdef LINE_FILL_MEM_WRITE_EN
    logic [OFF_W-1:0]      wcnt_q, wcnt_d;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_waddr;
    logic [DATA_WIDTH-1:0] mem_rd [MEM_DEPTH_WORDS];

    assign mem_we    = wr_valid && wr_ready;
    assign mem_waddr = {line_q, wcnt_q};

    // Storage is never reset; each word powers up holding its own index.
    for (genvar i = 0; i < MEM_DEPTH_WORDS; i++) begin : g_mem
        logic [DATA_WIDTH-1:0] cell_q = DATA_WIDTH'(i);

        always_ff @(posedge clk) begin
            if (mem_we && (mem_waddr == IDX_W'(i))) begin
                cell_q <= wr_data;
            end
        end

        assign mem_rd[i] = cell_q;
    end

    assign rd_data = mem_rd[rd_idx];
`else
    // Without the write path the contents are fixed: word i holds i.
    assign rd_data = DATA_WIDTH'(rd_idx);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef LINE_FILL_MEM_WRITE_EN
                    state_d = req_we ? S_WRITE : S_WAIT;
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_WAIT: begin
                if (lat_done) begin
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (beat_hs && (beat_q == LAST_BEAT)) begin
                    state_d = S_IDLE;
                end
            end
`ifdef LINE_FILL_MEM_WRITE_EN
            S_WRITE: begin
                if (mem_we && (wcnt_q == LAST_BEAT)) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic. req_ready is gated by rst_n so it reads 0 during reset.
    always_comb begin
        req_ready  = rst_n && (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        resp_valid = (state_q == S_BURST);
        resp_data  = data_q;
        resp_word  = word_q;
        resp_last  = last_q;
`ifdef LINE_FILL_MEM_WRITE_EN
        wr_ready   = (state_q == S_WRITE);
`endif
    end

    // Datapath next-state: request capture, latency count, beat registers.
    always_comb begin
        lat_d  = lat_q;
        line_d = line_q;
        off_d  = off_q;
        beat_d = beat_q;
        word_d = word_q;
        data_d = data_q;
        last_d = last_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Counter expires on the edge that presents the first beat.
                    lat_d  = LAT_W'(READ_LATENCY - 1);
                    line_d = req_idx[IDX_W-1:OFF_W];
                    off_d  = req_idx[OFF_W-1:0];
                end
            end
            S_WAIT: begin
                if (lat_done) begin
                    data_d = rd_data;
                    word_d = off_q;
                    beat_d = '0;
                    last_d = 1'b0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_BURST: begin
                if (beat_hs) begin
                    if (beat_q == LAST_BEAT) begin
                        last_d = 1'b0;
                    end else begin
                        data_d = rd_data;
                        word_d = nxt_word;
                        beat_d = nxt_beat;
                        last_d = (nxt_beat == LAST_BEAT);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q  <= '0;
            line_q <= '0;
            off_q  <= '0;
            beat_q <= '0;
            word_q <= '0;
            data_q <= '0;
            last_q <= 1'b0;
        end else begin
            lat_q  <= lat_d;
            line_q <= line_d;
            off_q  <= off_d;
            beat_q <= beat_d;
            word_q <= word_d;
            data_q <= data_d;
            last_q <= last_d;
        end
    end

`ifdef LINE_FILL_MEM_WRITE_EN
    // Write beats always start at word 0 of the line, whatever the offset.
    always_comb begin
        wcnt_d = wcnt_q;
        if ((state_q == S_IDLE) && accept) begin
            wcnt_d = '0;
        end else if (mem_we) begin
            wcnt_d = wcnt_q + OFF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_line_fill_mem.sv
// tb/tb_line_fill_mem.sv - self-checking bench for line_fill_mem
module tb_line_fill_mem;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int WPL   = 4;
    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_data;
    logic [1:0]    resp_word;
    logic          resp_last;
    logic          busy;
`ifdef LINE_FILL_MEM_WRITE_EN
    logic          req_we = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
`endif

    line_fill_mem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL),
        .MEM_DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_word(resp_word), .resp_last(resp_last),
`ifdef LINE_FILL_MEM_WRITE_EN
        .req_we(req_we), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    word;
        logic          last;
    } beat_t;

    logic [DW-1:0] model_mem [DEPTH];
    beat_t         exp_q [$];
    logic [DW-1:0] seen_data [$];
    logic [1:0]    seen_word [$];
    logic          seen_last [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a fill returns the whole line, starting at the requested word
    // and wrapping inside the line.
    task automatic model_fill(input logic [AW-1:0] addr);
        int idx, off, base, w;
        beat_t b;
        idx  = int'(addr >> 2) % DEPTH;
        off  = idx % WPL;
        base = idx - off;
        for (int k = 0; k < WPL; k++) begin
            w      = (off + k) % WPL;
            b.data = model_mem[base + w];
            b.word = 2'(w);
            b.last = (k == WPL - 1);
            exp_q.push_back(b);
        end
    endtask

    // Every presented beat must match the head of the expected queue; the
    // head is retired only when the handshake will complete.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got data %0h word %0d with no beat expected",
                         resp_data, resp_word);
            end else begin
                check("resp_data", resp_data, exp_q[0].data);
                check("resp_word", resp_word, exp_q[0].word);
                check("resp_last", resp_last, exp_q[0].last);
                if (resp_ready === 1'b1) begin
                    seen_data.push_back(resp_data);
                    seen_word.push_back(resp_word);
                    seen_last.push_back(resp_last);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic fill(input logic [AW-1:0] addr, input logic [15:0] pat, input int pat_len);
        int lat, pi, guard;
        check("req_ready_before_fill", req_ready, 1);
        seen_data.delete();
        seen_word.delete();
        seen_last.delete();
        model_fill(addr);
        req_valid = 1'b1;
        req_addr  = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("first_beat_latency", lat, LAT);
        pi = 0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 40) begin
            check("resp_valid_held", resp_valid, 1);
            check("req_ready_low_in_burst", req_ready, 0);
            resp_ready = (pi < pat_len) ? pat[pi] : 1'b1;
            pi++;
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL burst_timeout: %0d beats outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
        resp_ready = 1'b0;
        check("resp_valid_after_last", resp_valid, 0);
        check("req_ready_after_last", req_ready, 1);
        check("busy_after_last", busy, 0);
        check("beat_count", seen_data.size(), WPL);
    endtask

`ifdef LINE_FILL_MEM_WRITE_EN
    task automatic write_line(input logic [AW-1:0] addr, input logic [DW-1:0] d0,
                              input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                              input logic [DW-1:0] d3);
        logic [DW-1:0] d [4];
        int base, g;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        base = (int'(addr >> 2) % DEPTH) & ~(WPL - 1);
        req_we    = 1'b1;
        req_valid = 1'b1;
        req_addr  = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        for (int k = 0; k < WPL; k++) begin
            wr_valid = 1'b1;
            wr_data  = d[k];
            g = 0;
            while (wr_ready !== 1'b1 && g < 10) begin
                @(posedge clk); #1;
                g++;
            end
            check("wr_ready_seen", wr_ready, 1);
            @(posedge clk); #1;
            model_mem[base + k] = d[k];
        end
        wr_valid = 1'b0;
        check("write_done_idle", busy, 0);
        check("write_no_resp", resp_valid, 0);
    endtask
`endif

    initial begin
        int guard;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = DW'(i);

        // Reset held for two cycles.
        #1 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_word", resp_word, 0);
        check("rst_resp_last", resp_last, 0);
        check("rst_busy", busy, 0);
        #2 rst_n = 1'b1;
        #1;
        check("post_rst_req_ready", req_ready, 1);
        @(posedge clk); #1;

        // Critical word at offset 3, back-to-back beats.
        fill(32'h0000_005F, 16'h0000, 0);
        check("f5f_d0", seen_data[0], 23);
        check("f5f_d1", seen_data[1], 20);
        check("f5f_d2", seen_data[2], 21);
        check("f5f_d3", seen_data[3], 22);
        check("f5f_w0", seen_word[0], 3);
        check("f5f_w3", seen_word[3], 2);
        check("f5f_last2", seen_last[2], 0);
        check("f5f_last3", seen_last[3], 1);

        // Stalls: resp_ready 1,0,0,1,1,0,1.
        fill(32'h0000_0040, 16'b1011001, 7);
        check("f40_d0", seen_data[0], 16);
        check("f40_d1", seen_data[1], 17);
        check("f40_d2", seen_data[2], 18);
        check("f40_d3", seen_data[3], 19);

        // Address beyond storage depth wraps.
        fill(32'h0000_1018, 16'h0000, 0);
        check("f1018_d0", seen_data[0], 6);
        check("f1018_d1", seen_data[1], 7);
        check("f1018_d2", seen_data[2], 4);
        check("f1018_d3", seen_data[3], 5);
        check("f1018_last", seen_last[3], 1);

        // Reset after beat 1 of a burst.
        seen_data.delete();
        seen_word.delete();
        seen_last.delete();
        model_fill(32'h0000_005F);
        req_valid = 1'b1;
        req_addr  = 32'h0000_005F;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        guard = 0;
        while (seen_data.size() < 2 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("mid_beats_before_reset", seen_data.size(), 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_resp_data", resp_data, 0);
        exp_q.delete();
        resp_ready = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill(32'h0000_005F, 16'h0000, 0);
        check("refill_d0", seen_data[0], 23);
        check("refill_d1", seen_data[1], 20);
        check("refill_d2", seen_data[2], 21);
        check("refill_d3", seen_data[3], 22);

`ifdef LINE_FILL_MEM_WRITE_EN
        write_line(32'h0000_0040, 32'hDEADBEEF, 32'h1, 32'h2, 32'h3);
        @(posedge clk); #1;
        fill(32'h0000_0048, 16'h0000, 0);
        check("wr_d0", seen_data[0], 32'h2);
        check("wr_d1", seen_data[1], 32'h3);
        check("wr_d2", seen_data[2], 32'hDEADBEEF);
        check("wr_d3", seen_data[3], 32'h1);
        check("wr_w0", seen_word[0], 2);
        check("wr_w2", seen_word[2], 0);
`endif

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
